// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcodes, ALU codes, immediate formats and decode helpers
package rv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e f);
        return f == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               f == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
               f == IMM_U ? {i[31:12], 12'b0} :
               f == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                            {{20{i[31]}}, i[31:20]};
    endfunction

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
    function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
        return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
               f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 ? ALU_SLT :
               f3 == 3'd3 ? ALU_SLTU :
               f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == 3'd6 ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/id_stage_reg_file.sv
// reg_file: 32xXLEN register file, two async reads, one sync write, x0 hardwired to 0
// Optional write-first bypass when ID_WB_BYPASS_EN is defined.
module reg_file #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);
    logic [XLEN-1:0] r_regs [32];

    // clear on reset, commit writeback at the edge, never write x0
    always_ff @(posedge clk) begin
        if (i_reset)
            for (int k = 0; k < 32; k++) r_regs[k] <= '0;
        else if (i_we && i_wa != 5'd0)
            r_regs[i_wa] <= i_wd;
    end

`ifdef ID_WB_BYPASS_EN
    assign o_rd1 = i_ra1 == 5'd0 ? '0 : (i_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
    assign o_rd2 = i_ra2 == 5'd0 ? '0 : (i_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
`else
    assign o_rd1 = i_ra1 == 5'd0 ? '0 : r_regs[i_ra1];
    assign o_rd2 = i_ra2 == 5'd0 ? '0 : r_regs[i_ra2];
`endif
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with register file and ID/EX pipeline register
// Build option ID_WB_BYPASS_EN enables same-cycle writeback-to-read bypass.
module id_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     pc_in,
    input  logic [31:0]     instruction,
    input  logic            if_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [31:0]     id_pc,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [31:0]     imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            branch,
    output logic            jump,
    output logic [2:0]      funct3,
    output logic            illegal
);
    import rv_pkg::*;

    logic [31:0]     w_instr;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_f7b5;
    logic [XLEN-1:0] w_rd1, w_rd2;
    imm_fmt_e        w_fmt;
    alu_op_e         w_alu;
    logic w_alu_src, w_mem_read, w_mem_write, w_reg_write, w_branch, w_jump, w_illegal;

    assign w_instr = if_valid ? instruction : NOP_INSTR;
    assign w_opc   = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_f7b5  = w_instr[30];

    reg_file #(.XLEN(XLEN)) u_rf (
        .clk(clk), .i_reset(reset),
        .i_we(wb_we), .i_wa(wb_rd), .i_wd(wb_data),
        .i_ra1(w_instr[19:15]), .i_ra2(w_instr[24:20]),
        .o_rd1(w_rd1), .o_rd2(w_rd2)
    );

    // control decode; unknown opcodes leave every side effect off and raise illegal
    always_comb begin
        w_fmt       = IMM_I;
        w_alu       = ALU_ADD;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        case (w_opc)
            OP_R:      begin w_alu = alu_dec(w_f3, w_f7b5); w_reg_write = 1'b1; end
            OP_IMM:    begin w_alu = alu_dec(w_f3, w_f3 == 3'd5 && w_f7b5); w_alu_src = 1'b1; w_reg_write = 1'b1; end
            OP_LOAD:   begin w_alu_src = 1'b1; w_mem_read = 1'b1; w_reg_write = 1'b1; end
            OP_STORE:  begin w_fmt = IMM_S; w_alu_src = 1'b1; w_mem_write = 1'b1; end
            OP_BRANCH: begin w_fmt = IMM_B; w_branch = 1'b1; end
            OP_JAL:    begin w_fmt = IMM_J; w_alu_src = 1'b1; w_reg_write = 1'b1; w_jump = 1'b1; end
            OP_JALR:   begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_jump = 1'b1; end
            OP_LUI:    begin w_fmt = IMM_U; w_alu = ALU_PASSB; w_alu_src = 1'b1; w_reg_write = 1'b1; end
            OP_AUIPC:  begin w_fmt = IMM_U; w_alu_src = 1'b1; w_reg_write = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    // ID/EX register: reset and flush load an all-zero bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            imm        <= '0;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            alu_op     <= '0;
            alu_src    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            branch     <= 1'b0;
            jump       <= 1'b0;
            funct3     <= '0;
            illegal    <= 1'b0;
        end else if (!stall) begin
            id_valid   <= if_valid;
            id_pc      <= pc_in;
            rs1_data   <= w_rd1;
            rs2_data   <= w_rd2;
            imm        <= gen_imm(w_instr, w_fmt);
            rs1        <= w_instr[19:15];
            rs2        <= w_instr[24:20];
            rd         <= w_instr[11:7];
            alu_op     <= w_alu;
            alu_src    <= w_alu_src;
            mem_read   <= w_mem_read;
            mem_write  <= w_mem_write;
            mem_to_reg <= w_mem_read;
            reg_write  <= w_reg_write;
            branch     <= w_branch;
            jump       <= w_jump;
            funct3     <= w_f3;
            illegal    <= w_illegal;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset, if_valid, stall, flush, wb_we;
    logic [31:0] pc_in, instruction, wb_data;
    logic [4:0]  wb_rd;
    logic        id_valid, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, illegal;
    logic [31:0] id_pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_byp;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .instruction(instruction),
        .if_valid(if_valid), .stall(stall), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .branch(branch), .jump(jump), .funct3(funct3), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ID_WB_BYPASS_EN
        exp_byp = 32'hDEADBEEF;
`else
        exp_byp = 32'h0;
`endif
        reset = 1; if_valid = 0; stall = 0; flush = 0; wb_we = 0;
        pc_in = 0; instruction = 0; wb_rd = 0; wb_data = 0;
        tick; tick;
        check("rst_valid", id_valid, 0);
        check("rst_imm", imm, 0);
        check("rst_alu", alu_op, 0);
        check("rst_illegal", illegal, 0);
        check("rst_regwrite", reg_write, 0);
        reset = 0;

        if_valid = 1; pc_in = 32'h1000; instruction = 32'h00500093;
        tick;
        check("addi_valid", id_valid, 1);
        check("addi_pc", id_pc, 32'h1000);
        check("addi_rd", rd, 1);
        check("addi_imm", imm, 5);
        check("addi_alu", alu_op, 0);
        check("addi_src", alu_src, 1);
        check("addi_rw", reg_write, 1);

        pc_in = 32'h1004; instruction = 32'h123452B7;
        tick;
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu", alu_op, 10);
        check("lui_rd", rd, 5);

        if_valid = 0; wb_we = 1; wb_rd = 1; wb_data = 32'h100;
        tick;
        check("nop_valid", id_valid, 0);
        check("nop_rd", rd, 0);
        wb_rd = 2; wb_data = 32'h55;
        tick;
        wb_we = 0; if_valid = 1; instruction = 32'h0020A423;
        tick;
        check("sw_mw", mem_write, 1);
        check("sw_rw", reg_write, 0);
        check("sw_imm", imm, 8);
        check("sw_rs1d", rs1_data, 32'h100);
        check("sw_rs2d", rs2_data, 32'h55);
        check("sw_f3", funct3, 2);

        wb_we = 1; wb_rd = 3; wb_data = 32'hDEADBEEF; instruction = 32'h00018233;
        tick;
        wb_we = 0;
        check("byp_rs1d", rs1_data, exp_byp);
        check("add_rd", rd, 4);
        check("add_src", alu_src, 0);

        stall = 1; wb_we = 1; wb_rd = 3; wb_data = 32'h1234; instruction = 32'h123452B7;
        tick;
        wb_we = 0; instruction = 32'h0020A423;
        tick;
        instruction = 32'h0000007F;
        tick;
        check("stall_rd", rd, 4);
        check("stall_rs1d", rs1_data, exp_byp);
        check("stall_src", alu_src, 0);
        check("stall_rw", reg_write, 1);
        check("stall_ill", illegal, 0);
        stall = 0; instruction = 32'h00018233;
        tick;
        check("wb_in_stall", rs1_data, 32'h1234);

        stall = 1; flush = 1;
        tick;
        check("fl_valid", id_valid, 0);
        check("fl_rw", reg_write, 0);
        check("fl_rd", rd, 0);
        check("fl_pc", id_pc, 0);
        check("fl_rs1d", rs1_data, 0);
        stall = 0; flush = 0;

        instruction = 32'h00500093;
        tick;
        stall = 1; reset = 1;
        tick;
        check("rst_stall_valid", id_valid, 0);
        check("rst_stall_imm", imm, 0);
        reset = 0; stall = 0;

        instruction = 32'h0000007F;
        tick;
        check("ill_flag", illegal, 1);
        check("ill_valid", id_valid, 1);
        check("ill_rw", reg_write, 0);
        check("ill_mw", mem_write, 0);

        wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        tick;
        wb_we = 0; instruction = 32'h00500093;
        tick;
        check("x0_read", rs1_data, 0);

        instruction = 32'hFE208EE3;
        tick;
        check("beq_imm", imm, 32'hFFFFFFFC);
        check("beq_br", branch, 1);
        check("beq_rw", reg_write, 0);

        instruction = 32'h40000033;
        tick;
        check("sub_alu", alu_op, 1);
        instruction = 32'h4010D093;
        tick;
        check("srai_alu", alu_op, 7);
        instruction = 32'hC0000093;
        tick;
        check("addi_neg_alu", alu_op, 0);
        check("addi_neg_imm", imm, 32'hFFFFFC00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage RV32I pipeline. Sits directly downstream of the fetch stage: it consumes the fetched `pc`/`instruction` pair, decodes control signals and the immediate, reads the 32×32 register file, and registers everything into the ID/EX boundary. The writeback port of the register file also enters here.

## Interface

Parameters:
- `XLEN`, 32: datapath width.
- `NOP_INSTR`, 32'h0000_0013: `addi x0,x0,0` encoding, decoded on bubbles.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc_in`  in  32  PC of the fetched instruction.
- `instruction`  in  32  fetched instruction word.
- `if_valid`  in  1  fetch output is valid.
- `stall`  in  1  hold all ID/EX outputs and register file reads.
- `flush`  in  1  squash the current decode into a bubble.
- `wb_we`  in  1  register-file write enable.
- `wb_rd`  in  5  write address.
- `wb_data`  in  32  write data.
- `id_valid`  out  1  ID/EX slot holds a real instruction.
- `id_pc`  out  32  PC of the decoded instruction.
- `rs1_data`, `rs2_data`  out  32 each  operand values.
- `imm`  out  32  sign-extended immediate.
- `rs1`, `rs2`, `rd`  out  5 each  register indices; these drive the hazard unit.
- `alu_op`  out  4  ALU operation code.
- `alu_src`  out  1  1 selects `imm` as operand B.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`, `branch`, `jump`  out  1 each  control signals.
- `funct3`  out  3  forwarded to the branch and load/store units.
- `illegal`  out  1  unsupported opcode was decoded.

## Operation

- Supported opcodes:
  - R-type 0110011
  - OP-IMM 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - LUI 0110111
  - AUIPC 0010111
- Immediate formats are I/S/B/U/J, sign-extended to 32 bits. B and J immediates have bit 0 = 0.
- `alu_op` is derived from funct3/funct7[5]. SUB and SRA are selected only when funct7[5]=1; for OP-IMM, funct7[5] is honoured only for shifts.
- LUI uses PASSB. AUIPC, JAL and JALR use ADD.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Reset clears x1–x31 to 0.
- Any other opcode:
  - `illegal`=1 and `id_valid`=1.
  - All side-effect controls (`reg_write`, `mem_*`, `branch`, `jump`) are 0.
- When `if_valid`=0, the stage decodes `NOP_INSTR` and loads `id_valid`=0.
- Priority per edge: `reset` > `flush` > `stall` > normal load.
- Flush loads a bubble:
  - `id_valid`=0 and all controls 0.
  - `id_pc`, operand and index fields are 0.
- Stall holds every ID/EX output unchanged. A writeback still occurs during a stall. The held `rs*_data` is **not** refreshed by that writeback; forwarding handles it.

## Timing

- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Register file write is committed at the edge.
- Reset values: every output is 0, including `id_valid`, `illegal`, `alu_op` (ADD) and `imm`.
- Reset asserted mid-stall or mid-flush: outputs are 0 on the next edge.
- Simultaneous `flush` and `stall`: flush wins.
- Simultaneous writeback and read of the same register: see Configuration.
- Throughput: 1 instruction per cycle when not stalled.

## Configuration

- `ID_WB_BYPASS_EN` defined:
  - A read whose address equals `wb_rd` while `wb_we`=1 and `wb_rd`≠0 returns `wb_data` in the same cycle (write-first).
- Undefined:
  - Such a read returns the pre-write value.
  - The hazard unit must then insert one extra stall for a WB→ID dependency.

## Structure

- Shared package `rv_pkg` holds:
  - opcode constants
  - ALU codes ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10
  - immediate-format enum
  - `NOP_INSTR`
- One sub-module, `reg_file`: two async read ports, one sync write port, synchronous reset; bypass lives inside it under the macro.
- Decoder logic is combinational inside `id_stage`; the ID/EX register is in `id_stage`.

## Test plan

- Reset, then `addi x1,x0,5` (0x00500093) with `if_valid`=1 → next cycle:
  - `id_valid`=1, `rd`=1, `imm`=5, `alu_op`=ADD
  - `alu_src`=1, `reg_write`=1
- `lui x5,0x12345` (0x123452B7) → `imm`=0x12345000, `alu_op`=PASSB, `rd`=5.
- `sw x2,8(x1)` (0x0020A423) with x1=0x100, x2=0x55 preloaded via the WB port →
  - `mem_write`=1, `reg_write`=0, `imm`=8
  - `rs1_data`=0x100, `rs2_data`=0x55
- `wb_we`=1, `wb_rd`=3, `wb_data`=0xDEADBEEF in the same cycle as `add x4,x3,x0` (0x00018233) → `rs1_data`:
  - 0xDEADBEEF with `ID_WB_BYPASS_EN`
  - 0 without it
- `stall`=1 for 3 cycles while the input changes → outputs frozen. Then assert `flush` together with `stall` → `id_valid`=0 and all controls 0 next cycle.
- Opcode 0x0000007F → `illegal`=1, `id_valid`=1, `reg_write`=0. Write to x0 with 0xFFFF_FFFF, then read x0 → 0.
